// File: rtl/offchip_data_memory_if.sv
// Request/acknowledge bus between the dcache miss/write-back engine and
// the off-chip line memory. The requester drives addr/data/write/enable and
// holds them stable until the ack cycle; the memory answers with a one-cycle
// ack pulse and, for reads, the line on data_o during that pulse.
interface offchip_data_memory_if #(
  parameter int DATA_W = 256
);
  logic [31:0]       addr_i;
  logic [DATA_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;

  // Requester side (dcache engine)
  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  // Memory side
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/offchip_data_memory.sv
// Main memory behind the L1 data cache: DEPTH lines of DATA_W bits, one whole
// line per access, fixed LATENCY from the accepting edge to the ack pulse.
// A request accepted in IDLE moves to WAIT with count=1; the ack cycle is the
// one where count reaches LATENCY-1. Address, write flag and write data are
// only looked at in that ack cycle, and a write lands on the edge ending it.
// Line contents survive reset; only the handshake FSM is cleared.
module offchip_data_memory #(
  parameter int DATA_W  = 256,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input logic                  clk_i,
  input logic                  rst_i,
  offchip_data_memory_if.slave bus
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          OFS_W = $clog2(DATA_W / 8);
  localparam logic [3:0]  LAST  = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        count;
  logic [3:0]        count_next;
  logic              ack;
  logic [IDX_W-1:0]  line_idx;
  logic [DATA_W-1:0] memory [0:DEPTH-1];

  // Byte offset within a line and the bits above the array size are dropped,
  // so addresses alias modulo the memory size.
  assign line_idx = bus.addr_i[OFS_W +: IDX_W];

  // Ignored address bits are kept visible here so they do not look forgotten.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:OFS_W+IDX_W], bus.addr_i[OFS_W-1:0]};

  // Handshake state and latency counter; reset drops any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in the design samples pre-edge values, independent of block order.
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state and count update: IDLE accepts on enable, WAIT counts to LAST.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (bus.enable_i) begin
          state_next = WAIT;
          count_next = 4'd1;
        end else begin
          count_next = '0;
        end
      end
      WAIT: begin
        if (count == LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + 4'd1;
        end
      end
    endcase
  end

  // Completion pulse, combinational from the state register; enable_i is not
  // consulted in WAIT, so dropping it early does not abort the transaction.
  assign ack = (state == WAIT) && (count == LAST);

  assign bus.ack_o  = ack;
  assign bus.data_o = ack ? memory[line_idx] : '0;

  // Line write on the edge that ends the ack cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset branch on purpose: its contents must
    // survive reset, and a reset on a large array would prevent RAM mapping.
    if (ack && bus.write_i) begin
      memory[line_idx] <= bus.data_i;
    end
  end

endmodule

// File: tb/tb_offchip_data_memory.sv
// Directed bench for offchip_data_memory. Inputs change 1 ns after a rising
// edge and outputs are sampled there too. A request presented before edge E0
// is accepted at E0 (count=1); count reaches 9 after E8, so ack is seen 8
// edges after the accepting edge and a write lands at E9.
module tb_offchip_data_memory;

  typedef logic [255:0] line_t;

  localparam line_t PAT_BEEF = {8{32'hDEAD_BEEF}};
  localparam line_t PAT_ALIA = {8{32'h0123_4567}};
  localparam line_t PAT_CAFE = {8{32'hCAFE_F00D}};
  localparam line_t PAT_1357 = {8{32'h1357_9BDF}};
  localparam line_t ALL_ONES = '1;
  localparam int    ACK_EDGES = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  offchip_data_memory_if #(.DATA_W(256)) bus ();

  offchip_data_memory #(
    .DATA_W (256),
    .DEPTH  (512),
    .LATENCY(10)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input line_t data, input logic we);
    bus.addr_i   = addr;
    bus.data_i   = data;
    bus.write_i  = we;
    bus.enable_i = 1'b1;
  endtask

  // Called just after the accepting edge; counts edges until ack is visible.
  task automatic wait_ack(output int n);
    n = 0;
    while (bus.ack_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    bus.addr_i   = '0;
    bus.data_i   = '0;
    bus.write_i  = 1'b0;
    bus.enable_i = 1'b1;
    tick();
    tick();
    checks++;
    if (dut.state !== 1'b0) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    checks++;
    if (dut.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count); end
    checks++;
    if (bus.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack_o); end
    checks++;
    if (bus.data_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
    bus.enable_i = 1'b0;
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int n;
    logic leak;
    drive_req(32'h0000_0000, '0, 1'b0);
    tick();
    checks++;
    if (dut.state !== 1'b1 || dut.count !== 4'd1) begin
      errors++; $display("FAIL read_accept: got state=%0d count=%0d want 1/1", dut.state, dut.count);
    end
    n = 0;
    leak = 1'b0;
    while (bus.ack_o !== 1'b1 && n < 20) begin
      if (bus.data_o !== '0) leak = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != ACK_EDGES) begin errors++; $display("FAIL read_latency: got %0d edges want %0d", n, ACK_EDGES); end
    checks++;
    if (leak !== 1'b0) begin errors++; $display("FAIL read_data_early: got nonzero data_o before ack want 0"); end
    checks++;
    if (bus.data_o !== 256'h5) begin errors++; $display("FAIL read_data: got %h want 5", bus.data_o); end
    tick();
    bus.enable_i = 1'b0;
    checks++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
      errors++; $display("FAIL read_ack_width: got ack=%b data=%h want 0/0", bus.ack_o, bus.data_o);
    end
    tick();
    checks++;
    if (dut.state !== 1'b0) begin errors++; $display("FAIL read_idle: got state=%0d want 0", dut.state); end
  endtask

  task automatic test_write();
    int n;
    drive_req(32'h0000_0400, PAT_BEEF, 1'b1);
    tick();
    wait_ack(n);
    checks++;
    if (n != ACK_EDGES) begin errors++; $display("FAIL write_latency: got %0d want %0d", n, ACK_EDGES); end
    checks++;
    if (dut.memory[32] !== '0) begin errors++; $display("FAIL write_early: got %h want 0", dut.memory[32]); end
    tick();
    checks++;
    if (dut.memory[32] !== PAT_BEEF) begin
      errors++; $display("FAIL write_line: got %h want %h", dut.memory[32], PAT_BEEF);
    end
    drive_req(32'h0000_0400, '0, 1'b0);
    tick();
    wait_ack(n);
    checks++;
    if (bus.data_o !== PAT_BEEF) begin
      errors++; $display("FAIL write_readback: got %h want %h", bus.data_o, PAT_BEEF);
    end
    tick();
    bus.enable_i = 1'b0;
    tick();
  endtask

  task automatic test_alias();
    int n;
    drive_req(32'h0000_4020, PAT_ALIA, 1'b1);
    tick();
    wait_ack(n);
    tick();
    bus.enable_i = 1'b0;
    checks++;
    if (dut.memory[1] !== PAT_ALIA) begin
      errors++; $display("FAIL alias_line1: got %h want %h", dut.memory[1], PAT_ALIA);
    end
    checks++;
    if (dut.memory[0] !== 256'h5) begin errors++; $display("FAIL alias_line0: got %h want 5", dut.memory[0]); end
    tick();
  endtask

  task automatic test_pulse_back_to_back();
    int n;
    drive_req(32'h0000_0000, '0, 1'b0);
    tick();
    bus.enable_i = 1'b0;
    wait_ack(n);
    checks++;
    if (n != ACK_EDGES) begin errors++; $display("FAIL pulse_latency: got %0d want %0d", n, ACK_EDGES); end
    checks++;
    if (bus.data_o !== 256'h5) begin errors++; $display("FAIL pulse_data: got %h want 5", bus.data_o); end
    tick();
    checks++;
    if (dut.state !== 1'b0) begin errors++; $display("FAIL b2b_gap: got state=%0d want 0", dut.state); end
    drive_req(32'h0000_0400, '0, 1'b0);
    tick();
    bus.enable_i = 1'b0;
    checks++;
    if (dut.state !== 1'b1 || dut.count !== 4'd1) begin
      errors++; $display("FAIL b2b_accept: got state=%0d count=%0d want 1/1", dut.state, dut.count);
    end
    wait_ack(n);
    checks++;
    if (n != ACK_EDGES || bus.data_o !== PAT_BEEF) begin
      errors++; $display("FAIL b2b_second: got edges=%0d data=%h want %0d/%h", n, bus.data_o, ACK_EDGES, PAT_BEEF);
    end
    tick();
  endtask

  task automatic test_reset_during_write();
    logic seen;
    drive_req(32'h0000_0040, ALL_ONES, 1'b1);
    tick();
    bus.enable_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (dut.count !== 4'd5) begin errors++; $display("FAIL rstw_count5: got %0d want 5", dut.count); end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (dut.state !== 1'b0 || dut.count !== 4'd0 || bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL rstw_async: got state=%0d count=%0d ack=%b want 0/0/0", dut.state, dut.count, bus.ack_o);
    end
    tick();
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.ack_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstw_no_ack: got ack pulse want none"); end
    checks++;
    if (dut.memory[2] !== PAT_CAFE) begin
      errors++; $display("FAIL rstw_memory: got %h want %h", dut.memory[2], PAT_CAFE);
    end
  endtask

  task automatic test_read_ignores_data();
    int n;
    drive_req(32'h0000_0060, ALL_ONES, 1'b0);
    tick();
    wait_ack(n);
    checks++;
    if (n != ACK_EDGES || bus.data_o !== PAT_1357) begin
      errors++; $display("FAIL rdata_out: got edges=%0d data=%h want %0d/%h", n, bus.data_o, ACK_EDGES, PAT_1357);
    end
    tick();
    bus.enable_i = 1'b0;
    checks++;
    if (dut.memory[3] !== PAT_1357) begin
      errors++; $display("FAIL rdata_memory: got %h want %h", dut.memory[3], PAT_1357);
    end
    tick();
  endtask

  initial begin
    dut.memory[0]  = 256'h5;
    dut.memory[1]  = '0;
    dut.memory[2]  = PAT_CAFE;
    dut.memory[3]  = PAT_1357;
    dut.memory[32] = '0;
    test_reset();
    test_read();
    test_write();
    test_alias();
    test_pulse_back_to_back();
    test_reset_during_write();
    test_read_ignores_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion want finish before 100000 ns");
    $fatal(1);
  end

endmodule
